// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit frame engine.
package uart_pkg;

    localparam int OSR_DEFAULT = 16;
    localparam int WLEN_MIN    = 5;
    localparam int CNT_W       = $clog2(2 * OSR_DEFAULT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    function automatic logic calc_parity(input logic [8:0] data, input logic [3:0] wlen,
                                         input logic eps, input logic stick);
        logic [8:0] m;
        m = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            if (i < 32'(wlen)) m[i] = data[i];
        end
        if (stick) return ~eps;
        return eps ? ^m : ~^m;
    endfunction

    function automatic int stop_ticks(input logic stb, input logic [3:0] wlen, input int osr);
        if (!stb) return osr;
        if (wlen == 4'd5) return (osr * 3) / 2;
        return 2 * osr;
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Loadable down-counter of baud ticks; tc flags the last tick of the loaded span.
module uart_tx_bit_timer
    import uart_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = tick && (cnt == '0);

endmodule

// File: rtl/uart_tx_frame_engine.sv
// UART transmit serialiser: pops characters from the TX FIFO and emits
// start / data / optional parity / stop framing at OSR baud ticks per bit.
module uart_tx_frame_engine
    import uart_pkg::*;
#(
    parameter int OSR    = 16,
    parameter int DATA_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         baud_pulse,
    input  logic [DATA_W-1:0]            din,
    input  logic                         din_valid,
    output logic                         pop,
    input  logic [$clog2(DATA_W+1)-1:0]  wlen,
    input  logic                         pen,
    input  logic                         eps,
    input  logic                         stick,
    input  logic                         stb,
    input  logic                         set_break,
    output logic                         tx,
    output logic                         busy,
    output logic                         sreg_empty,
    output logic                         frame_done
);

    localparam int WL_W = $clog2(DATA_W + 1);
    localparam int TW   = $clog2(2 * OSR);

    tx_state_t         state, state_nx;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] din_masked;
    logic [WL_W-1:0]   wlen_eff;
    logic [WL_W-1:0]   bits_left;
    logic [WL_W-1:0]   cfg_wlen;
    logic              cfg_pen;
    logic              cfg_stb;
    logic              par_bit;
    logic              line_bit;
    logic              load_char;
    logic              shift;
    logic              done_nx;
    logic              empty_set;
    logic              tmr_load;
    logic [TW-1:0]     tmr_val;
    logic              tc;

    uart_tx_bit_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (baud_pulse),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tc)
    );

    always_comb begin
        if (wlen < WL_W'(WLEN_MIN)) begin
            wlen_eff = WL_W'(WLEN_MIN);
        end else if (wlen > WL_W'(DATA_W)) begin
            wlen_eff = WL_W'(DATA_W);
        end else begin
            wlen_eff = wlen;
        end
        din_masked = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (i < 32'(wlen_eff)) din_masked[i] = din[i];
        end
    end

    always_comb begin
        state_nx  = state;
        load_char = 1'b0;
        shift     = 1'b0;
        done_nx   = 1'b0;
        empty_set = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            IDLE: begin
                if (baud_pulse && din_valid) begin
                    state_nx  = START;
                    load_char = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = TW'(OSR - 1);
                end
            end
            START: begin
                if (tc) begin
                    state_nx = DATA;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(OSR - 1);
                end
            end
            DATA: begin
                if (tc) begin
                    shift    = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(OSR - 1);
                    if (bits_left == WL_W'(1)) begin
                        empty_set = 1'b1;
                        if (cfg_pen) begin
                            state_nx = PARITY;
                        end else begin
                            state_nx = STOP;
                            tmr_val  = TW'(stop_ticks(cfg_stb, 4'(cfg_wlen), OSR) - 1);
                        end
                    end
                end
            end
            PARITY: begin
                if (tc) begin
                    state_nx = STOP;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(stop_ticks(cfg_stb, 4'(cfg_wlen), OSR) - 1);
                end
            end
            STOP: begin
                if (tc) begin
                    done_nx = 1'b1;
                    // Chain straight into the next start bit when the FIFO has data.
                    if (din_valid) begin
                        state_nx  = START;
                        load_char = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_val   = TW'(OSR - 1);
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        case (state)
            START:   line_bit = 1'b0;
            DATA:    line_bit = shreg[0];
            PARITY:  line_bit = par_bit;
            default: line_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            bits_left  <= '0;
            cfg_wlen   <= '0;
            cfg_pen    <= 1'b0;
            cfg_stb    <= 1'b0;
            par_bit    <= 1'b0;
            pop        <= 1'b0;
            frame_done <= 1'b0;
            sreg_empty <= 1'b1;
            tx         <= 1'b1;
        end else begin
            pop        <= load_char;
            frame_done <= done_nx;
            tx         <= line_bit & ~set_break;
            if (load_char) begin
                shreg      <= din_masked;
                bits_left  <= wlen_eff;
                cfg_wlen   <= wlen_eff;
                cfg_pen    <= pen;
                cfg_stb    <= stb;
                par_bit    <= calc_parity(9'(din_masked), 4'(wlen_eff), eps, stick);
                sreg_empty <= 1'b0;
            end else begin
                if (shift) begin
                    shreg     <= shreg >> 1;
                    bits_left <= bits_left - WL_W'(1);
                end
                if (empty_set) sreg_empty <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Self-checking bench for uart_tx_frame_engine (OSR=16, DATA_W=8, baud tick every clk).
module tb_uart_tx_frame_engine;

    localparam int OSR = 16;
    localparam int DW  = 8;

    logic       clk = 1'b0;
    logic       rst, baud_pulse, din_valid, pop;
    logic [7:0] din;
    logic [3:0] wlen;
    logic       pen, eps, stick, stb, set_break;
    logic       tx, busy, sreg_empty, frame_done;

    int   pass_cnt = 0;
    int   total    = 0;
    logic cap[$];
    logic expq[$];
    int   done_at;
    int   xpops;
    logic e_mid, e_end;

    typedef struct {
        logic [7:0] din;
        int         wl;
        logic       pen, eps, stick, stb;
        int         x_eff;
        logic [7:0] x_data;
        logic       x_par;
        int         x_len;
    } vec_t;

    vec_t tbl[10];

    uart_tx_frame_engine #(.OSR(OSR), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_pulse (baud_pulse),
        .din        (din),
        .din_valid  (din_valid),
        .pop        (pop),
        .wlen       (wlen),
        .pen        (pen),
        .eps        (eps),
        .stick      (stick),
        .stb        (stb),
        .set_break  (set_break),
        .tx         (tx),
        .busy       (busy),
        .sreg_empty (sreg_empty),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d required %0d", name, got, exp);
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %b required %b", name, got, exp);
    endtask

    // Expected line level per baud tick, appended to expq.
    function automatic void model_frame(input logic [7:0] d, input int wl, input logic p,
                                        input logic e, input logic s, input logic sb);
        int   eff, ones, st;
        logic pb;
        eff  = (wl < 5) ? 5 : ((wl > DW) ? DW : wl);
        ones = 0;
        for (int unsigned t = 0; t < OSR; t++) expq.push_back(1'b0);
        for (int i = 0; i < eff; i++) begin
            if (d[i]) ones++;
            for (int unsigned t = 0; t < OSR; t++) expq.push_back(d[i]);
        end
        if (p) begin
            pb = s ? ~e : (((ones % 2) == 1) == e);
            for (int unsigned t = 0; t < OSR; t++) expq.push_back(pb);
        end
        st = !sb ? OSR : ((eff == 5) ? (OSR * 3) / 2 : 2 * OSR);
        for (int t = 0; t < st; t++) expq.push_back(1'b1);
    endfunction

    task automatic start_frame(input logic [7:0] d, input int wl, input logic p, input logic e,
                               input logic s, input logic sb, output bit ok);
        int g;
        g = 0;
        din = d; wlen = 4'(wl); pen = p; eps = e; stick = s; stb = sb; din_valid = 1'b1;
        @(negedge clk);
        while (!pop && g < 20) begin
            @(negedge clk);
            g++;
        end
        ok = pop;
        din_valid = 1'b0;
        // Scramble config mid-frame; only the latched copy may matter.
        din = 8'($urandom); wlen = 4'($urandom); pen = 1'($urandom);
        eps = 1'($urandom); stick = 1'($urandom); stb = 1'($urandom);
        if (!ok) check_int("pop_timeout", 0, 1);
    endtask

    task automatic capture(input int brk_at, input int brk_len);
        cap.delete();
        done_at = -1;
        xpops   = 0;
        e_mid   = 1'bx;
        e_end   = 1'bx;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            cap.push_back(tx);
            if (pop) xpops++;
            if (k == 3 * OSR) e_mid = sreg_empty;
            if (frame_done) begin
                done_at = k;
                e_end   = sreg_empty;
                break;
            end
            if (k == brk_at) set_break = 1'b1;
            if (k == brk_at + brk_len) set_break = 1'b0;
        end
        set_break = 1'b0;
    endtask

    task automatic cmp_wave(input string name);
        int nm, first;
        nm = 0;
        first = -1;
        for (int i = 0; i < cap.size() && i < expq.size(); i++) begin
            if (cap[i] !== expq[i]) begin
                nm++;
                if (first < 0) first = i;
            end
        end
        total++;
        if (nm == 0 && cap.size() == expq.size()) pass_cnt++;
        else $display("FAIL %s wave: %0d bad samples (first %0d), length %0d required %0d",
                      name, nm, first, cap.size(), expq.size());
        check_int({name, " done_at"}, done_at, expq.size() - 1);
    endtask

    initial begin
        bit         ok;
        logic [7:0] got_d;
        logic [7:0] chars[3];
        int         pops, dones, busy_low, lows;

        tbl[0] = '{8'h55, 8,  1'b0, 1'b0, 1'b0, 1'b0, 8, 8'h55, 1'b0, 160};
        tbl[1] = '{8'h83, 7,  1'b1, 1'b1, 1'b0, 1'b0, 7, 8'h03, 1'b0, 160};
        tbl[2] = '{8'h83, 7,  1'b1, 1'b0, 1'b0, 1'b0, 7, 8'h03, 1'b1, 160};
        tbl[3] = '{8'hA5, 8,  1'b1, 1'b0, 1'b1, 1'b0, 8, 8'hA5, 1'b1, 176};
        tbl[4] = '{8'hA5, 8,  1'b1, 1'b1, 1'b1, 1'b0, 8, 8'hA5, 1'b0, 176};
        tbl[5] = '{8'h1F, 5,  1'b0, 1'b0, 1'b0, 1'b1, 5, 8'h1F, 1'b0, 120};
        tbl[6] = '{8'h3F, 6,  1'b0, 1'b0, 1'b0, 1'b1, 6, 8'h3F, 1'b0, 144};
        tbl[7] = '{8'hFF, 3,  1'b0, 1'b0, 1'b0, 1'b0, 5, 8'h1F, 1'b0, 112};
        tbl[8] = '{8'hFF, 15, 1'b0, 1'b0, 1'b0, 1'b0, 8, 8'hFF, 1'b0, 160};
        tbl[9] = '{8'h00, 5,  1'b1, 1'b0, 1'b0, 1'b0, 5, 8'h00, 1'b1, 128};

        rst = 1'b1; baud_pulse = 1'b1; din_valid = 1'b0; din = '0; wlen = 4'd8;
        pen = 1'b0; eps = 1'b0; stick = 1'b0; stb = 1'b0; set_break = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("reset tx", tx, 1'b1);
        check_bit("reset pop", pop, 1'b0);
        check_bit("reset busy", busy, 1'b0);
        check_bit("reset sreg_empty", sreg_empty, 1'b1);
        check_bit("reset frame_done", frame_done, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        for (int unsigned v = 0; v < 10; v++) begin
            start_frame(tbl[v].din, tbl[v].wl, tbl[v].pen, tbl[v].eps, tbl[v].stick, tbl[v].stb, ok);
            if (ok) begin
                capture(-1, 0);
                expq.delete();
                model_frame(tbl[v].din, tbl[v].wl, tbl[v].pen, tbl[v].eps, tbl[v].stick, tbl[v].stb);
                cmp_wave($sformatf("tbl%0d", v));
                check_int($sformatf("tbl%0d length", v), done_at + 1, tbl[v].x_len);
                got_d = '0;
                for (int i = 0; i < tbl[v].x_eff; i++) begin
                    if (OSR * (1 + i) + OSR / 2 < cap.size()) got_d[i] = cap[OSR * (1 + i) + OSR / 2];
                end
                check_int($sformatf("tbl%0d data", v), int'(got_d), int'(tbl[v].x_data));
                if (tbl[v].pen) begin
                    if (OSR * (1 + tbl[v].x_eff) + OSR / 2 < cap.size())
                        check_bit($sformatf("tbl%0d parity", v),
                                  cap[OSR * (1 + tbl[v].x_eff) + OSR / 2], tbl[v].x_par);
                    else
                        check_int($sformatf("tbl%0d parity sample", v), cap.size(), tbl[v].x_len);
                end
                check_int($sformatf("tbl%0d sreg_empty mid/end", v), int'({e_mid, e_end}), 1);
                check_int($sformatf("tbl%0d extra pops", v), xpops, 0);
            end
            @(negedge clk);
        end

        for (int unsigned r = 0; r < 20; r++) begin
            logic [7:0] d;
            int         wl;
            logic       p, e, s, sb;
            d = 8'($urandom); wl = int'($urandom_range(0, 15));
            p = 1'($urandom); e = 1'($urandom); s = 1'($urandom); sb = 1'($urandom);
            start_frame(d, wl, p, e, s, sb, ok);
            if (ok) begin
                capture(-1, 0);
                expq.delete();
                model_frame(d, wl, p, e, s, sb);
                cmp_wave($sformatf("rnd%0d d=%h wl=%0d p=%b e=%b s=%b sb=%b", r, d, wl, p, e, s, sb));
                check_int($sformatf("rnd%0d extra pops", r), xpops, 0);
            end
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        // Three queued characters: frames must abut with no idle tick.
        chars[0] = 8'h3C; chars[1] = 8'hA7; chars[2] = 8'h01;
        din = chars[0]; wlen = 4'd8; pen = 1'b1; eps = 1'b1; stick = 1'b0; stb = 1'b1;
        din_valid = 1'b1;
        pops = 0;
        for (int g = 0; g < 20 && pops == 0; g++) begin
            @(negedge clk);
            if (pop) pops = 1;
        end
        check_int("b2b first pop", pops, 1);
        din = chars[1];
        dones = 0; busy_low = 0; done_at = -1;
        cap.delete();
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            cap.push_back(tx);
            if (pop) begin
                pops++;
                if (pops == 2) din = chars[2];
                if (pops >= 3) din_valid = 1'b0;
            end
            if (frame_done) begin
                dones++;
                if (dones == 3) begin
                    done_at = k;
                    break;
                end
            end
            if (!busy) busy_low++;
        end
        din_valid = 1'b0;
        expq.delete();
        for (int unsigned i = 0; i < 3; i++) model_frame(chars[i], 8, 1'b1, 1'b1, 1'b0, 1'b1);
        cmp_wave("b2b");
        check_int("b2b pops", pops, 3);
        check_int("b2b frame_done pulses", dones, 3);
        check_int("b2b busy low cycles", busy_low, 0);
        @(negedge clk);

        // Break held for 20 samples mid-frame; the frame keeps its timing underneath.
        start_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, ok);
        if (ok) begin
            capture(40, 20);
            expq.delete();
            model_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0);
            for (int unsigned i = 41; i <= 60; i++) expq[i] = 1'b0;
            cmp_wave("break");
        end
        @(negedge clk);

        // Reset while DATA is driving a 0.
        start_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, ok);
        if (ok) begin
            repeat (40) @(negedge clk);
            check_bit("pre-reset tx", tx, 1'b0);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_bit("mid reset tx", tx, 1'b1);
            check_bit("mid reset busy", busy, 1'b0);
            check_bit("mid reset sreg_empty", sreg_empty, 1'b1);
            check_bit("mid reset pop", pop, 1'b0);
            pops = 0; dones = 0; lows = 0;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                if (pop) pops++;
                if (frame_done) dones++;
                if (!tx) lows++;
            end
            check_int("post reset pops", pops, 0);
            check_int("post reset frame_done", dones, 0);
            check_int("post reset tx low cycles", lows, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
